// File: rtl/microwave_pkg.sv
// rtl/microwave_pkg.sv - shared states, key codes and quick-start constant for microwave_time_entry
package microwave_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_RUN   = 3'd2,
    ST_PAUSE = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam logic [3:0] KEY_CLEAR_CODE = 4'd10;
  localparam logic [3:0] KEY_START_CODE = 4'd11;
  localparam logic [3:0] KEY_STOP_CODE  = 4'd12;

  // 0:30 packed as {min_ones, sec_tens, sec_ones}
  localparam logic [11:0] QUICK_START_BCD = 12'h030;

  // the seconds-tens counter is mod-6, so anything above 5 loads as 5
  function automatic logic [3:0] sat_tens(input logic [3:0] d);
    return (d > 4'd5) ? 4'd5 : d;
  endfunction

endpackage

// File: rtl/bcd_entry_shift.sv
// rtl/bcd_entry_shift.sv - 3-digit BCD keypad entry register with left shift, preset and clear
module bcd_entry_shift (
  input  logic        clock,
  input  logic        clear,
  input  logic        shift_en,
  input  logic [3:0]  digit,
  input  logic        clear_en,
  input  logic        preset_en,
  input  logic [11:0] preset_data,
  output logic [11:0] entry
);

  always_ff @(posedge clock) begin
    if (!clear || clear_en) begin
      entry <= 12'h000;
    end else if (preset_en) begin
      entry <= preset_data;
    end else if (shift_en) begin
      entry <= {entry[7:0], digit};
    end
  end

endmodule

// File: rtl/microwave_time_entry.sv
// rtl/microwave_time_entry.sv - keypad time entry and cooking-cycle FSM; MICROWAVE_QUICK_START_EN enables 0:30 quick start
module microwave_time_entry
  import microwave_pkg::*;
#(
  parameter logic [3:0] KEY_CLEAR = KEY_CLEAR_CODE,
  parameter logic [3:0] KEY_START = KEY_START_CODE,
  parameter logic [3:0] KEY_STOP  = KEY_STOP_CODE
) (
  input  logic       clock,
  input  logic       clear,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  input  logic       door_closed,
  input  logic       tick,
  input  logic       timer_zero,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       loadn,
  output logic       count_en,
  output logic       heat_on,
  output logic       done
);

  localparam logic [2:0] IDLE  = ST_IDLE;
  localparam logic [2:0] LOAD  = ST_LOAD;
  localparam logic [2:0] RUN   = ST_RUN;
  localparam logic [2:0] PAUSE = ST_PAUSE;
  localparam logic [2:0] DONE  = ST_DONE;

  logic [2:0]  state;
  logic [2:0]  state_nxt;
  logic [11:0] entry;
  logic [11:0] held;
  logic [11:0] load_view;
  logic        in_idle, in_load, in_run, in_pause, in_done;
  logic        key_digit, key_clr, key_start, key_stop;
  logic        start_ok, go_load, quick;
  logic        shift_en, clear_en;

  assign in_idle  = (state == IDLE);
  assign in_load  = (state == LOAD);
  assign in_run   = (state == RUN);
  assign in_pause = (state == PAUSE);
  assign in_done  = (state == DONE);

  assign key_digit = key_valid && (key_code <= 4'd9);
  assign key_clr   = key_valid && (key_code == KEY_CLEAR);
  assign key_start = key_valid && (key_code == KEY_START);
  assign key_stop  = key_valid && (key_code == KEY_STOP);

  assign start_ok = in_idle && key_start && door_closed;

`ifdef MICROWAVE_QUICK_START_EN
  assign quick   = start_ok && (entry == 12'h000);
  assign go_load = start_ok;
`else
  assign quick   = 1'b0;
  assign go_load = start_ok && (entry != 12'h000);
`endif

  assign shift_en = in_idle && key_digit;
  assign clear_en = (in_idle && key_clr) || (in_pause && key_stop && !(key_start && door_closed)) || in_done;

  bcd_entry_shift u_entry (
    .clock       (clock),
    .clear       (clear),
    .shift_en    (shift_en),
    .digit       (key_code),
    .clear_en    (clear_en),
    .preset_en   (quick),
    .preset_data (QUICK_START_BCD),
    .entry       (entry)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (go_load) state_nxt = LOAD;
      LOAD:    state_nxt = RUN;
      RUN: begin
        // the chain reaching zero wins over a door or stop event in the same cycle
        if (timer_zero)        state_nxt = DONE;
        else if (!door_closed) state_nxt = PAUSE;
        else if (key_stop)     state_nxt = PAUSE;
      end
      PAUSE: begin
        if (key_start && door_closed) state_nxt = RUN;
        else if (key_stop)            state_nxt = IDLE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!clear) state <= IDLE;
    else        state <= state_nxt;
  end

  assign load_view = {entry[11:8], sat_tens(entry[7:4]), entry[3:0]};

  // counters keep their own copy after the load; outputs just hold it for reference
  always_ff @(posedge clock) begin
    if (!clear)       held <= 12'h000;
    else if (in_load) held <= load_view;
  end

  assign {min_ones, sec_tens, sec_ones} = in_load ? load_view : held;

  assign loadn    = !in_load;
  assign count_en = in_run && tick && door_closed;
  assign heat_on  = in_run && door_closed;
  assign done     = in_done;

endmodule
